// File: rtl/pb_event_if.sv
// ---------------------------------------------------------------------------
// pb_event_if -- CPU data-bus bundle for the push-button event peripheral.
//
// Signals:
//   addr [7:0]  CPU address
//   din  [7:0]  CPU write data
//   we          write strobe, one cycle per write
//   re          read strobe, one cycle per read
//   out  [7:0]  read data from the peripheral (8'h00 when not addressed)
//
// Modports:
//   master -- CPU side, drives addr/din/we/re and receives out
//   slave  -- peripheral side, receives addr/din/we/re and drives out
// ---------------------------------------------------------------------------
interface pb_event_if;
   logic [7:0] addr;
   logic [7:0] din;
   logic       we;
   logic       re;
   logic [7:0] out;

   modport master (output addr, output din, output we, output re, input out);
   modport slave  (input addr, input din, input we, input re, output out);
endinterface

// File: rtl/pb_event.sv
// ---------------------------------------------------------------------------
// pb_event -- push-button edge detector with an 8-entry event FIFO,
// sticky pending flags, interrupt mask and overflow flag.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   state [4:0] debounced button levels, 1 = pressed
//   bus         pb_event_if.slave CPU bus (addr, din, we, re -> out)
//   irq         registered interrupt request, active-high
//
// Register map:
//   0xF9  R: {3'b0, pending}         W: write-1-to-clear pending
//   0xFA  R: FIFO head (0 if empty)  re pops the head
//   0xFB  R: {ovf, full, empty, 1'b0, count}   W: din[7]=1 clears ovf
//   0xFC  R/W: interrupt mask, bits 4:0
//
// Configuration macro:
//   PB_EVENT_RELEASE_EN -- when defined, release edges are queued and
//   pushed as events with bit7 set; otherwise only presses are reported.
// ---------------------------------------------------------------------------
module pb_event (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] state,
   pb_event_if.slave  bus,
   output logic       irq
);

   localparam logic [7:0] ADDR_PEND = 8'hF9;
   localparam logic [7:0] ADDR_FIFO = 8'hFA;
   localparam logic [7:0] ADDR_STAT = 8'hFB;
   localparam logic [7:0] ADDR_MASK = 8'hFC;

   logic [4:0] prev_q, prev_d;
   logic [4:0] pending_q, pending_d;
   logic [4:0] press_q, press_d;
   logic [4:0] mask_q, mask_d;
   logic [7:0] mem_q [8];
   logic [7:0] mem_d [8];
   logic [2:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] rd_ptr_q, rd_ptr_d;
   logic [3:0] count_q, count_d;
   logic       ovf_q, ovf_d;
   logic       irq_q, irq_d;
`ifdef PB_EVENT_RELEASE_EN
   logic [4:0] rel_q, rel_d;
`endif

   logic [4:0] press_edge_s;
   logic [4:0] sel_press_s;
   logic [4:0] sel_rel_s;
   logic       found_s;
   logic       is_rel_s;
   logic [2:0] sel_idx_s;
   logic [7:0] entry_s;
   logic       full_s;
   logic       empty_s;
   logic       pop_s;
   logic       push_ok_s;
   logic       ovf_set_s;
   logic [4:0] w1c_s;
   logic       ovf_clr_s;

   assign full_s  = (count_q == 4'd8);
   assign empty_s = (count_q == 4'd0);

   // Pick one queued event: lowest press index first, then lowest release.
   always_comb begin
      sel_press_s = 5'b00000;
      sel_rel_s   = 5'b00000;
      found_s     = 1'b0;
      is_rel_s    = 1'b0;
      sel_idx_s   = 3'd0;
      for (int i = 0; i < 5; i++) begin
         sel_press_s[i] = press_q[i] & ~found_s;
         sel_idx_s      = sel_press_s[i] ? 3'(i) : sel_idx_s;
         found_s        = found_s | press_q[i];
      end
`ifdef PB_EVENT_RELEASE_EN
      for (int i = 0; i < 5; i++) begin
         sel_rel_s[i] = rel_q[i] & ~found_s;
         sel_idx_s    = sel_rel_s[i] ? 3'(i) : sel_idx_s;
         is_rel_s     = is_rel_s | sel_rel_s[i];
         found_s      = found_s | rel_q[i];
      end
`endif
      entry_s = {is_rel_s, 1'b1, 3'b000, sel_idx_s};
   end

   // Next-state logic for edges, flags, queues and the FIFO.
   always_comb begin
      press_edge_s = state & ~prev_q;
      prev_d       = state;
      pop_s        = bus.re && (bus.addr == ADDR_FIFO) && !empty_s;
      // A full FIFO still accepts a push when a pop frees the head slot.
      push_ok_s    = found_s && (!full_s || pop_s);
      ovf_set_s    = found_s && full_s && !pop_s;
      w1c_s        = (bus.we && (bus.addr == ADDR_PEND)) ? bus.din[4:0] : 5'b00000;
      ovf_clr_s    = bus.we && (bus.addr == ADDR_STAT) && bus.din[7];

      pending_d = (pending_q & ~w1c_s) | press_edge_s;
      press_d   = (press_q & ~sel_press_s) | press_edge_s;
`ifdef PB_EVENT_RELEASE_EN
      rel_d     = (rel_q & ~sel_rel_s) | (~state & prev_q);
`endif
      mask_d    = (bus.we && (bus.addr == ADDR_MASK)) ? bus.din[4:0] : mask_q;
      ovf_d     = (ovf_q & ~ovf_clr_s) | ovf_set_s;
      irq_d     = (|(pending_q & mask_q)) | ovf_q;

      mem_d = mem_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = entry_s;
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      wr_ptr_d = push_ok_s ? (wr_ptr_q + 3'd1) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + 3'd1) : rd_ptr_q;

      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   // Read-data decode; zero outside the peripheral's window.
   always_comb begin
      case (bus.addr)
         ADDR_PEND: bus.out = {3'b000, pending_q};
         ADDR_FIFO: bus.out = empty_s ? 8'h00 : mem_q[rd_ptr_q];
         ADDR_STAT: bus.out = {ovf_q, full_s, empty_s, 1'b0, count_q};
         ADDR_MASK: bus.out = {3'b000, mask_q};
         default:   bus.out = 8'h00;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q    <= 5'b00000;
         pending_q <= 5'b00000;
         press_q   <= 5'b00000;
`ifdef PB_EVENT_RELEASE_EN
         rel_q     <= 5'b00000;
`endif
         mask_q    <= 5'b00000;
         wr_ptr_q  <= 3'd0;
         rd_ptr_q  <= 3'd0;
         count_q   <= 4'd0;
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
         press_q   <= press_d;
`ifdef PB_EVENT_RELEASE_EN
         rel_q     <= rel_d;
`endif
         mask_q    <= mask_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
         mem_q     <= mem_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_pb_event.sv
// ---------------------------------------------------------------------------
// tb_pb_event -- self-checking bench for pb_event. Directed scenarios plus a
// randomized run compared against an event-level model (sets of queued
// events and a FIFO queue).
// ---------------------------------------------------------------------------
module tb_pb_event;

`ifdef PB_EVENT_RELEASE_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [4:0] state;
   logic       irq;
   int         tests;
   int         fails;

   pb_event_if bus ();

   pb_event dut (
      .clk   (clk),
      .rst   (rst),
      .state (state),
      .bus   (bus.slave),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   logic [4:0] m_prev, m_pend, m_mask, m_pset, m_rset;
   bit         m_ovf, m_irq;
   logic [7:0] m_fifo [$];

   function automatic logic [7:0] model_read(logic [7:0] a);
      logic [7:0] r;
      case (a)
         8'hF9:   r = {3'b000, m_pend};
         8'hFA:   r = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
         8'hFB:   r = {m_ovf, m_fifo.size() == 8, m_fifo.size() == 0, 1'b0, 4'(m_fifo.size())};
         8'hFC:   r = {3'b000, m_mask};
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Advance the model with the current inputs, then the DUT by one clock.
   task automatic tick();
      logic [4:0] pr, rl, w1c;
      int         sel;
      bit         selrel, pop, ovfset, ovfclr, nirq;
      nirq = (|(m_pend & m_mask)) | m_ovf;
      if (rst) begin
         m_prev = 5'b0; m_pend = 5'b0; m_mask = 5'b0; m_pset = 5'b0; m_rset = 5'b0;
         m_ovf = 1'b0; nirq = 1'b0; m_fifo.delete();
      end else begin
         sel = -1; selrel = 1'b0;
         for (int n = 0; n < 5; n++) if (sel < 0 && m_pset[n]) sel = n;
         for (int n = 0; n < 5; n++) if (sel < 0 && m_rset[n]) begin sel = n; selrel = 1'b1; end
         if (sel >= 0) begin
            if (selrel) m_rset[sel] = 1'b0;
            else m_pset[sel] = 1'b0;
         end
         pr = state & ~m_prev;
         rl = REL ? (~state & m_prev) : 5'b0;
         pop = bus.re && (bus.addr == 8'hFA) && (m_fifo.size() > 0);
         if (pop) void'(m_fifo.pop_front());
         ovfset = 1'b0;
         if (sel >= 0) begin
            if (m_fifo.size() < 8) m_fifo.push_back({selrel, 1'b1, 3'b000, 3'(sel)});
            else ovfset = 1'b1;
         end
         w1c = (bus.we && bus.addr == 8'hF9) ? bus.din[4:0] : 5'b0;
         m_pend = (m_pend & ~w1c) | pr;
         m_pset = m_pset | pr;
         m_rset = m_rset | rl;
         if (bus.we && bus.addr == 8'hFC) m_mask = bus.din[4:0];
         ovfclr = bus.we && (bus.addr == 8'hFB) && bus.din[7];
         m_ovf = (m_ovf & ~ovfclr) | ovfset;
         m_prev = state;
      end
      m_irq = nirq;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; state = 5'b0; bus.we = 1'b0; bus.re = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      bus.addr = a; bus.din = d; bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
   endtask

   task automatic bus_pop();
      bus.addr = 8'hFA; bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; state = 5'b0; bus.we = 1'b0; bus.re = 1'b0;
      bus.addr = 8'h00; bus.din = 8'h00;
      tick(); tick();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h20) begin fails++; $display("FAIL reset_stat got=%h exp=%h", bus.out, 8'h20); end
      bus.addr = 8'hF9; #1;
      tests++; if (bus.out !== 8'h00) begin fails++; $display("FAIL reset_pend got=%h exp=%h", bus.out, 8'h00); end
      bus.addr = 8'hFC; #1;
      tests++; if (bus.out !== 8'h00) begin fails++; $display("FAIL reset_mask got=%h exp=%h", bus.out, 8'h00); end
      bus.addr = 8'h10; #1;
      tests++; if (bus.out !== 8'h00) begin fails++; $display("FAIL reset_unmapped got=%h exp=%h", bus.out, 8'h00); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=%b", irq, 1'b0); end
      rst = 1'b0;
   endtask

   task automatic test_single_press();
      do_reset();
      state = 5'b00001;
      tick(); tick();
      bus.addr = 8'hF9; #1;
      tests++; if (bus.out !== 8'h01) begin fails++; $display("FAIL single_pend got=%h exp=%h", bus.out, 8'h01); end
      bus.addr = 8'hFA; #1;
      tests++; if (bus.out !== 8'h40) begin fails++; $display("FAIL single_head got=%h exp=%h", bus.out, 8'h40); end
      bus_pop();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h20) begin fails++; $display("FAIL single_stat got=%h exp=%h", bus.out, 8'h20); end
      bus_pop();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h20) begin fails++; $display("FAIL empty_pop_stat got=%h exp=%h", bus.out, 8'h20); end
   endtask

   task automatic test_two_press();
      do_reset();
      state = 5'b10100;
      tick(); tick(); tick();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h02) begin fails++; $display("FAIL two_stat got=%h exp=%h", bus.out, 8'h02); end
      bus.addr = 8'hFA; #1;
      tests++; if (bus.out !== 8'h42) begin fails++; $display("FAIL two_first got=%h exp=%h", bus.out, 8'h42); end
      bus_pop();
      bus.addr = 8'hFA; #1;
      tests++; if (bus.out !== 8'h44) begin fails++; $display("FAIL two_second got=%h exp=%h", bus.out, 8'h44); end
   endtask

   task automatic test_irq();
      do_reset();
      bus_write(8'hFC, 8'h01);
      state = 5'b00001;
      tick();
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_early got=%b exp=%b", irq, 1'b0); end
      tick();
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set got=%b exp=%b", irq, 1'b1); end
      bus_write(8'hF9, 8'h01);
      tick();
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got=%b exp=%b", irq, 1'b0); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      do_reset();
      state = 5'h1F; repeat (7) tick();
      state = 5'h00; repeat (7) tick();
      state = 5'h0F; repeat (7) tick();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'hC8) begin fails++; $display("FAIL ovf_stat got=%h exp=%h", bus.out, 8'hC8); end
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL ovf_irq got=%b exp=%b", irq, 1'b1); end
      bus_write(8'hFB, 8'h80);
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h48) begin fails++; $display("FAIL ovf_clear got=%h exp=%h", bus.out, 8'h48); end
      for (int i = 0; i < 8; i++) begin
         if (i < 5) exp = 8'h40 + 8'(i);
         else exp = (REL ? 8'hC0 : 8'h40) + 8'(i - 5);
         bus.addr = 8'hFA; #1;
         tests++; if (bus.out !== exp) begin fails++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, bus.out, exp); end
         bus_pop();
      end
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h20) begin fails++; $display("FAIL ovf_drained got=%h exp=%h", bus.out, 8'h20); end
   endtask

   task automatic test_release();
      logic [7:0] exp;
      do_reset();
      state = 5'b01000; repeat (3) tick();
      state = 5'b00000; repeat (3) tick();
      exp = REL ? 8'h02 : 8'h01;
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== exp) begin fails++; $display("FAIL rel_count got=%h exp=%h", bus.out, exp); end
      bus.addr = 8'hFA; #1;
      tests++; if (bus.out !== 8'h43) begin fails++; $display("FAIL rel_press got=%h exp=%h", bus.out, 8'h43); end
      bus_pop();
      exp = REL ? 8'hC3 : 8'h00;
      bus.addr = 8'hFA; #1;
      tests++; if (bus.out !== exp) begin fails++; $display("FAIL rel_release got=%h exp=%h", bus.out, exp); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus_write(8'hFC, 8'h1F);
      state = 5'h0F; repeat (6) tick();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h04) begin fails++; $display("FAIL mid_pre_stat got=%h exp=%h", bus.out, 8'h04); end
      tests++; if (irq !== 1'b1) begin fails++; $display("FAIL mid_pre_irq got=%b exp=%b", irq, 1'b1); end
      rst = 1'b1; state = 5'h00;
      tick();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h20) begin fails++; $display("FAIL mid_in_rst got=%h exp=%h", bus.out, 8'h20); end
      rst = 1'b0;
      tick();
      bus.addr = 8'hFB; #1;
      tests++; if (bus.out !== 8'h20) begin fails++; $display("FAIL mid_stat got=%h exp=%h", bus.out, 8'h20); end
      bus.addr = 8'hF9; #1;
      tests++; if (bus.out !== 8'h00) begin fails++; $display("FAIL mid_pend got=%h exp=%h", bus.out, 8'h00); end
      bus.addr = 8'hFA; #1;
      tests++; if (bus.out !== 8'h00) begin fails++; $display("FAIL mid_head got=%h exp=%h", bus.out, 8'h00); end
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq got=%b exp=%b", irq, 1'b0); end
   endtask

   task automatic test_random();
      logic [7:0] exp;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 5) == 0) state = 5'($urandom_range(0, 31));
         bus.addr = 8'hF8 + 8'($urandom_range(0, 5));
         bus.din  = 8'($urandom);
         bus.we   = ($urandom_range(0, 7) == 0);
         bus.re   = ($urandom_range(0, 2) == 0);
         #1;
         exp = model_read(bus.addr);
         tests++; if (bus.out !== exp) begin fails++; $display("FAIL rnd_read c=%0d addr=%h got=%h exp=%h", c, bus.addr, bus.out, exp); end
         tests++; if (irq !== m_irq) begin fails++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, m_irq); end
         tick();
      end
      bus.we = 1'b0; bus.re = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      test_reset();
      test_single_press();
      test_two_press();
      test_irq();
      test_overflow();
      test_release();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pb_event.md
PB_EVENT -- requirements
Module: pb_event

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port state  input  5  debounced push-button levels from the pb debouncer, bit n = button n, 1 = pressed.
REQ-004 SHALL have port addr  input  8  CPU data-bus address.
REQ-005 SHALL have port din  input  8  CPU write data.
REQ-006 SHALL have port we  input  1  write strobe, one cycle per write.
REQ-007 SHALL have port re  input  1  read strobe, one cycle per read.
REQ-008 SHALL have port out  output  8  read data; 8'h00 whenever addr is not 0xF9-0xFC, so it can be OR-combined with other peripherals.
REQ-009 SHALL have port irq  output  1  registered interrupt request, active-high.

Function
REQ-010 SHALL register state once into prev; press edge n = state[n] & ~prev[n]; release edge n = ~state[n] & prev[n].
REQ-011 SHALL set pending[n] on every press edge n; pending[n] stays set until cleared (sticky).
REQ-012 SHALL clear pending[n] on a write to 0xF9 with din[n]=1 (write-1-to-clear); a same-cycle press edge on n wins and leaves pending[n]=1.
REQ-013 SHALL hold detected edges in a press-queue mask and a release-queue mask, and push exactly one event per cycle into an 8-entry FIFO: lowest button index first, presses before releases.
REQ-014 SHALL encode each FIFO entry as bit7 = 1 for release / 0 for press, bit6 = 1 (valid), bits5:3 = 0, bits2:0 = button index.
REQ-015 SHALL, when addr=0xFA, drive out = FIFO head combinationally (8'h00 if the FIFO is empty); re with addr=0xFA and FIFO non-empty pops the head at the clock edge.
REQ-016 SHALL ignore a pop on an empty FIFO; count and pointers are unchanged.
REQ-017 SHALL, on a push into a full FIFO, drop the event, set sticky ovf, and leave FIFO contents unchanged; a push and pop in the same cycle on a full FIFO both succeed and count stays 8.
REQ-018 SHALL use 3-bit read/write pointers that wrap 7->0 and a 4-bit count in the range 0..8.
REQ-019 SHALL return on a read of 0xFB: {ovf, full, empty, 1'b0, count[3:0]}; a write to 0xFB with din[7]=1 clears ovf, and a same-cycle overflow wins.
REQ-020 SHALL hold an interrupt mask at 0xFC (read/write, bits4:0 used, bits7:5 read 0).
REQ-021 SHALL return {3'b0, pending} on a read of 0xF9.
REQ-022 SHALL register irq one cycle after the condition: irq = |(pending & mask) | ovf.

Reset
REQ-023 SHALL, while rst=1, clear prev, pending, both queue masks, mask, ovf, pointers, count and irq to 0; out follows addr decode with an empty FIFO, so 0xFB reads 8'h20.
REQ-024 SHALL, when rst asserts mid-operation, discard all queued and stored events immediately; no event from before reset is visible afterwards.
REQ-025 SHALL load prev with 0 at reset, so a button already held at reset release produces one press event.

Configuration
REQ-026 SHALL, with PB_EVENT_RELEASE_EN defined, queue and push release events as in REQ-013/REQ-014.
REQ-027 SHALL, without PB_EVENT_RELEASE_EN, not implement the release-queue mask, never push release events, and never set bit7 of any entry; all other behaviour is identical.

Verification
REQ-028 SHALL check: reset, then state 0->5'b00001 -> after 2 cycles 0xF9 reads 0x01 and 0xFA reads 0x40; read of 0xFA pops, then 0xFB reads 0x20.
REQ-029 SHALL check: state 0->5'b10100 in one cycle -> FIFO holds 0x42 then 0x44 in that order, count 2.
REQ-030 SHALL check: mask=0x01 and press on button 0 -> irq=1 one cycle after pending sets; write 0x01 to 0xF9 -> irq=0 on the next cycle.
REQ-031 SHALL check: 9 press events with no reads -> 0xFB reads 0xC8, irq=1, and the 9th event is absent; write 0x80 to 0xFB -> ovf clears.
REQ-032 SHALL check, with PB_EVENT_RELEASE_EN: press then release of button 3 -> entries 0x43, 0xC3; without the macro -> only 0x43.
REQ-033 SHALL check: assert rst with 4 entries queued -> after reset 0xFB reads 0x20, 0xF9 reads 0x00, irq=0.
